// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults, image window geometry and shared types
// for the VGA scanout path.
package vga_pkg;

  // 640x480@60 timing, 25 MHz pixel clock
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  // Centred 256x256 image window
  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int IMG_X0 = 192;
  localparam int IMG_Y0 = 112;

  localparam logic [11:0] BG_RGB = 12'h000;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef logic [15:0] fb_addr_t;

  // Inclusive range test on counter values widened to int
  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v counters plus the stage-0 decodes
// (active video, raw sync pulses, frame boundary pulse).
module vga_timing #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       frame_start
);

  localparam int HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC - 1;

  // Pixel/line counters; v advances on every h wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (int'(h_cnt) == HT - 1) begin
      h_cnt <= '0;
      if (int'(v_cnt) == VT - 1) v_cnt <= '0;
      else                       v_cnt <= v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
  assign hs_raw = (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) <= HS_END);
  assign vs_raw = (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) <= VS_END);

  // Undelayed: gives the upstream stage the whole vertical blank to swap buffers
  assign frame_start = (h_cnt == '0) && (int'(v_cnt) == V_ACTIVE);

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing plus a two-stage fetch/colour pipeline that shows a
// 256x256 framebuffer window centred in 640x480. Syncs are delayed to line up
// with RGB. Optional macro VGA_SCANOUT_BORDER_EN draws a white 1-pixel ring
// just outside the window.
module vga_scanout #(
  parameter int          H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int          H_FP     = vga_pkg::H_FP,
  parameter int          H_SYNC   = vga_pkg::H_SYNC,
  parameter int          H_BP     = vga_pkg::H_BP,
  parameter int          V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int          V_FP     = vga_pkg::V_FP,
  parameter int          V_SYNC   = vga_pkg::V_SYNC,
  parameter int          V_BP     = vga_pkg::V_BP,
  parameter int          IMG_X0   = vga_pkg::IMG_X0,
  parameter int          IMG_Y0   = vga_pkg::IMG_Y0,
  parameter logic [11:0] BG_RGB   = vga_pkg::BG_RGB
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fb_rd_en,
  output logic [15:0] fb_addr,
  input  logic [15:0] fb_r,
  input  logic [15:0] fb_g,
  input  logic [15:0] fb_b,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);
  import vga_pkg::*;

  logic [9:0] h_cnt, v_cnt;
  logic       active, hs_raw, vs_raw;
  logic       in_win, ring;
  logic [7:0] x_off, y_off;
  logic       act1, ring1, hs1, vs1;
  rgb12_t     pix_nxt;
  logic       fb_unused;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .active     (active),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .frame_start(frame_start)
  );

  // Stage 0: window decode and 8-bit window-relative coordinates
  assign in_win = in_rng(int'(h_cnt), IMG_X0, IMG_X0 + IMG_W - 1) &&
                  in_rng(int'(v_cnt), IMG_Y0, IMG_Y0 + IMG_H - 1);
  assign x_off  = h_cnt[7:0] - 8'(IMG_X0);
  assign y_off  = v_cnt[7:0] - 8'(IMG_Y0);

`ifdef VGA_SCANOUT_BORDER_EN
  logic on_col, on_row;
  assign on_col = ((int'(h_cnt) == IMG_X0 - 1) || (int'(h_cnt) == IMG_X0 + IMG_W)) &&
                  in_rng(int'(v_cnt), IMG_Y0 - 1, IMG_Y0 + IMG_H);
  assign on_row = ((int'(v_cnt) == IMG_Y0 - 1) || (int'(v_cnt) == IMG_Y0 + IMG_H)) &&
                  in_rng(int'(h_cnt), IMG_X0 - 1, IMG_X0 + IMG_W);
  assign ring   = on_col || on_row;
`else
  assign ring   = 1'b0;
`endif

  // Stage 1: issue the read; address holds outside the window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_rd_en <= 1'b0;
      fb_addr  <= '0;
      act1     <= 1'b0;
      ring1    <= 1'b0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
    end else begin
      fb_rd_en <= in_win;
      act1     <= active;
      ring1    <= ring;
      hs1      <= hs_raw;
      vs1      <= vs_raw;
      if (in_win) fb_addr <= fb_addr_t'({y_off, x_off});
    end
  end

  // Colour select: fetched pixel, then ring, then background, blanking is black.
  // fb_rd_en doubles as the delayed in_win, so fb data is ignored when it is low.
  always_comb begin
    pix_nxt = '0;
    if (fb_rd_en)           pix_nxt = '{r: fb_r[15:12], g: fb_g[15:12], b: fb_b[15:12]};
    else if (act1 && ring1) pix_nxt = '{r: 4'hF, g: 4'hF, b: 4'hF};
    else if (act1)          pix_nxt = rgb12_t'(BG_RGB);
  end

  // Stage 2: pin registers; syncs ride along so they land with the RGB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= pix_nxt.r;
      vga_g  <= pix_nxt.g;
      vga_b  <= pix_nxt.b;
      vga_hs <= ~hs1;
      vga_vs <= ~vs1;
    end
  end

  // Only the top nibble of each fb word is displayed
  assign fb_unused = ^{fb_r[11:0], fb_g[11:0], fb_b[11:0]};

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of vga_scanout. One instance uses the
// 640x480 defaults (line timing, reset); a second uses a shrunk raster with
// the same 256x256 window so full-frame behaviour fits in a short run.
// Ring expectations follow VGA_SCANOUT_BORDER_EN.
module tb_vga_scanout;

  localparam logic [11:0] S_BG = 12'h5A3;
`ifdef VGA_SCANOUT_BORDER_EN
  localparam logic [11:0] RING_RGB = 12'hFFF;
`else
  localparam logic [11:0] RING_RGB = S_BG;
`endif

  logic clk, rst;
  int   checks, errors, pos, fs_cnt;

  logic        d_rd, d_hs, d_vs, d_fs;
  logic [15:0] d_addr, d_fr, d_fg, d_fb;
  logic [3:0]  d_r, d_g, d_b;
  logic        s_rd, s_hs, s_vs, s_fs;
  logic [15:0] s_addr, s_fr, s_fg, s_fb;
  logic [3:0]  s_r, s_g, s_b;

  vga_scanout u_d (
    .clk(clk), .rst(rst), .fb_rd_en(d_rd), .fb_addr(d_addr),
    .fb_r(d_fr), .fb_g(d_fg), .fb_b(d_fb),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .vga_hs(d_hs), .vga_vs(d_vs), .frame_start(d_fs)
  );

  // 268 x 262 raster: active 260x258, window at (2,1)
  vga_scanout #(
    .H_ACTIVE(260), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(258), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .IMG_X0(2), .IMG_Y0(1), .BG_RGB(S_BG)
  ) u_s (
    .clk(clk), .rst(rst), .fb_rd_en(s_rd), .fb_addr(s_addr),
    .fb_r(s_fr), .fb_g(s_fg), .fb_b(s_fb),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .vga_hs(s_hs), .vga_vs(s_vs), .frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer read port whose address register is fb_addr: data is ready
  // by the edge after the strobe. r/g/b carry addr nibbles 15:12/11:8/7:4;
  // junk (E) when not reading.
  always_comb begin
    d_fr = 16'hE000; d_fg = 16'hE000; d_fb = 16'hE000;
    if (d_rd) begin
      d_fr = {d_addr[15:12], 12'h0}; d_fg = {d_addr[11:8], 12'h0}; d_fb = {d_addr[7:4], 12'h0};
    end
  end
  always_comb begin
    s_fr = 16'hE000; s_fg = 16'hE000; s_fb = 16'hE000;
    if (s_rd) begin
      s_fr = {s_addr[15:12], 12'h0}; s_fg = {s_addr[11:8], 12'h0}; s_fb = {s_addr[7:4], 12'h0};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pos = counter value driving the current period (cycles since release)
  task automatic step();
    @(posedge clk);
    #2;
    pos++;
    if (s_fs) fs_cnt++;
  endtask

  task automatic go(input int t);
    while (pos < t) step();
  endtask

  initial begin
    checks = 0; errors = 0; pos = 0; fs_cnt = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_hs",   d_hs, 1'b1);
    chk("rst_vs",   d_vs, 1'b1);
    chk("rst_rgb",  {d_r, d_g, d_b}, 12'h000);
    chk("rst_rd",   d_rd, 1'b0);
    chk("rst_addr", d_addr, 16'h0000);
    chk("rst_fs",   d_fs, 1'b0);
    chk("rst_srgb", {s_r, s_g, s_b}, 12'h000);

    rst = 1'b1;
    // Default raster, line 0
    go(101);  chk("d_rd_outside", d_rd, 1'b0);
    go(102);  chk("d_rgb_bg_h100", {d_r, d_g, d_b}, 12'h000);
    go(657);  chk("d_hs_657", d_hs, 1'b1);
    go(658);  chk("d_hs_658", d_hs, 1'b0);
    go(700);  chk("d_vs_line0", d_vs, 1'b1);
    go(702);  chk("d_rgb_blank_h700", {d_r, d_g, d_b}, 12'h000);
    go(753);  chk("d_hs_753", d_hs, 1'b0);
    go(754);  chk("d_hs_754", d_hs, 1'b1);

    // Mid-line reset at default h=300, v=1; small raster is inside its window
    go(1100);
    chk("s_addr_pre", s_addr, 16'h0319);
    chk("s_rgb_pre",  {s_r, s_g, s_b}, 12'h031);
    #1 rst = 1'b0;
    #1;
    chk("arst_addr", s_addr, 16'h0000);
    chk("arst_rd",   s_rd, 1'b0);
    chk("arst_rgb",  {s_r, s_g, s_b}, 12'h000);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1; pos = 0; fs_cnt = 0;

    go(271);   chk("s_rd_first",   s_rd, 1'b1);
               chk("s_addr_first", s_addr, 16'h0000);
    go(272);   chk("s_rgb_first",  {s_r, s_g, s_b}, 12'h000);
    go(657);   chk("d_hs_657_rel", d_hs, 1'b1);
    go(658);   chk("d_hs_658_rel", d_hs, 1'b0);
    go(1341);  chk("s_rd_bg", s_rd, 1'b0);
    go(1342);  chk("s_rgb_bg", {s_r, s_g, s_b}, S_BG);
    go(1604);  chk("s_rgb_blank", {s_r, s_g, s_b}, 12'h000);
    go(26803); chk("s_rgb_ring_left", {s_r, s_g, s_b}, RING_RGB);
    go(45103); chk("s_addr_a74c", s_addr, 16'hA74C);
    go(45104); chk("s_rgb_a74", {s_r, s_g, s_b}, 12'hA74);
    go(68866); chk("s_addr_ffff", s_addr, 16'hFFFF);
               chk("s_rd_last", s_rd, 1'b1);
    go(68867); chk("s_rgb_fff", {s_r, s_g, s_b}, 12'hFFF);
               chk("s_rd_off", s_rd, 1'b0);
               chk("s_addr_hold", s_addr, 16'hFFFF);
    go(68868); chk("s_rgb_ring_right", {s_r, s_g, s_b}, RING_RGB);
    go(68869); chk("s_rgb_bg_right", {s_r, s_g, s_b}, S_BG);
    go(68870); chk("s_rgb_blank_right", {s_r, s_g, s_b}, 12'h000);
    go(69143); chk("s_fs_pre", s_fs, 1'b0);
    go(69144); chk("s_fs_pulse", s_fs, 1'b1);
    go(69145); chk("s_fs_post", s_fs, 1'b0);
    go(69413); chk("s_vs_pre", s_vs, 1'b1);
    go(69414); chk("s_vs_first", s_vs, 1'b0);
    go(69949); chk("s_vs_last", s_vs, 1'b0);
    go(69950); chk("s_vs_post", s_vs, 1'b1);
    go(70216); chk("s_fs_count", fs_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Downstream consumer of VGAGraph's 256x256 framebuffer.
- Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Fetches pixels for a centred 256x256 image window through a synchronous read port and drives 4-bit-per-channel RGB with hsync/vsync.
- Emits a frame-boundary pulse so the upstream graph/path stage can swap or refresh its buffer during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- IMG_X0, 192, first column of image window
- IMG_Y0, 112, first line of image window
- BG_RGB, 12'h000, colour outside the window during active video

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- fb_rd_en  out  1  framebuffer read strobe
- fb_addr  out  16  {y[7:0], x[7:0]} framebuffer address
- fb_r  in  16  red word, valid one cycle after fb_rd_en
- fb_g  in  16  green word, same timing
- fb_b  in  16  blue word, same timing
- vga_r  out  4  red output
- vga_g  out  4  green output
- vga_b  out  4  blue output
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- frame_start  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Reset (rst=0, asynchronous):
  - h_cnt=0, v_cnt=0.
  - fb_rd_en=0, fb_addr=0.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, frame_start=0.
  - Pipeline valid/sync shadow registers are cleared.
- Counters:
  - First rising edge after release evaluates h_cnt=0, v_cnt=0 (cycle 0).
  - h_cnt wraps at H_TOTAL-1 = 799 to 0.
  - v_cnt increments on each h wrap and wraps at V_TOTAL-1 = 524 to 0.
  - Frame length is 420000 cycles.
- Stage 0 (counter stage):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - in_win = IMG_X0<=h_cnt<IMG_X0+256 && IMG_Y0<=v_cnt<IMG_Y0+256.
  - hs_raw = h_cnt in [656, 751]. vs_raw = v_cnt in [490, 491].
- Stage 1 (registered):
  - fb_rd_en = in_win.
  - fb_addr = {(v_cnt-IMG_Y0)[7:0], (h_cnt-IMG_X0)[7:0]}. The subtraction is truncated to 8 bits.
  - fb_addr holds its last value when in_win=0.
- Stage 2 (registered):
  - vga_r/g/b = fb_x[15:12] if the delayed in_win is set.
  - Otherwise BG_RGB nibbles if the delayed active is set.
  - Otherwise 0 (blanking forces black).
- Sync alignment:
  - vga_hs=~hs_raw and vga_vs=~vs_raw, each delayed 2 cycles to align with RGB.
  - Total latency from counter to pins is 2 cycles.
- frame_start:
  - Combinational on stage 0 (not delayed): asserted when h_cnt==0 && v_cnt==V_ACTIVE.
  - Exactly one pulse per frame.
- Other rules:
  - No back-pressure. fb_r/g/b are sampled unconditionally and ignored when the delayed in_win=0.
  - Reset mid-frame: all state returns to reset values immediately. Timing restarts at h=0,v=0 after release, with no partial pulse on frame_start.
  - Counter widths: h_cnt 10 bits, v_cnt 10 bits. Comparisons are unsigned.

Optional Feature:
- Macro VGA_SCANOUT_BORDER_EN.
- When defined: pixels on the 1-pixel ring just outside the image window (h=IMG_X0-1 or IMG_X0+256 with v in [IMG_Y0-1, IMG_Y0+256], and the symmetric vertical case) output 4'hF on all channels. Timing and fb_rd_en are unchanged.
- When undefined: those pixels output BG_RGB.

Decomposition:
- Package vga_pkg:
  - 640x480 timing localparams (H_TOTAL=800, V_TOTAL=525).
  - Window size IMG_W=IMG_H=256.
  - typedef rgb12_t {r,g,b 4-bit}.
  - typedef fb_addr_t logic[15:0].
- Sub-module vga_timing:
  - Counters plus active/hs_raw/vs_raw/frame_start.
  - vga_scanout adds the fetch pipeline and colour mux.

Test Plan:
- Reset release, run 800 cycles -> vga_hs low exactly on cycles 658..753, high elsewhere; vga_vs stays 1 on line 0.
- Run 420000 cycles -> frame_start pulses once, at cycle 480*800=384000; vga_vs low on cycles 490*800+2 through 492*800+1.
- Model fb returning fb_r={addr[15:12], 12'h0} one cycle after fb_rd_en.
  - At h=192, v=112: fb_addr=16'h0000, fb_rd_en=1 on cycle 1 of that pixel.
  - vga_r reflects the data 2 cycles after the counter stage.
  - At h=447, v=367: fb_addr=16'hFFFF.
- h=100, v=200 (active, outside window) -> fb_rd_en=0, RGB=BG_RGB. h=700 (blanking) -> RGB=0.
- Assert rst=0 mid-line (h=300, v=150) -> outputs reset asynchronously within the same cycle. After release, hsync first falls at cycle 658.
- With VGA_SCANOUT_BORDER_EN: pixel h=191, v=200 -> RGB=F/F/F. Without it -> BG_RGB.
